// File: rtl/rb_ctrl_pkg.sv
// Shared parameters for the packed row-buffer path: pixel/BRAM geometry,
// default image size, controller state encoding and a slot-rotation helper.
// Latency: n/a (declarations only). Backpressure: n/a.
//
// The write port (A) is one pixel wide. The read port (B) returns RBs pixels
// packed into one word. Lane k of read word x is write address x*RBs + k.
package rb_ctrl_pkg;

  localparam int PIXEL_WIDTH       = 8;
  localparam int RBs               = 4;
  localparam int BRAM_DEPTH        = 256;
  localparam int BRAM_W_ADDR_WIDTH = $clog2(BRAM_DEPTH);
  localparam int BRAM_W_DATA_WIDTH = PIXEL_WIDTH;
  localparam int BRAM_R_ADDR_WIDTH = $clog2(BRAM_DEPTH / RBs);
  localparam int BRAM_R_DATA_WIDTH = PIXEL_WIDTH * RBs;

  // Default image geometry. IMG_W*RBs must fit in BRAM_DEPTH, and IMG_H >= RBs.
  localparam int IMG_W_DEF = 64;
  localparam int IMG_H_DEF = 64;

  // Slot index width. Kept at one bit minimum so that RBs == 1 still elaborates.
  localparam int RB_SLOT_W = (RBs > 1) ? $clog2(RBs) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } rb_state_t;

  // Row-buffer slot rotation, modulo RBs.
  function automatic logic [RB_SLOT_W-1:0] next_slot(input logic [RB_SLOT_W-1:0] s);
    return (int'(s) == RBs - 1) ? '0 : s + 1'b1;
  endfunction

endpackage

// File: rtl/rb_raster_cnt.sv
// Raster position counters (x, y, row-buffer slot) with wrap and position flags.
// Latency: counters advance on the edge that ends an accept cycle; flags are combinational.
// Backpressure: none of its own; holds while adv is low.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   clear        zero all counters (start of frame)
//   adv          one pixel accepted this cycle
//   x, y, slot   current raster column, line and row-buffer slot
//   last_pix     current pixel is (IMG_W-1, IMG_H-1)
//   fill_last    current pixel is the last one of line RBs-2 (end of fill phase)
//   win_ok       current line is at least RBs-1, so a full window column exists
module rb_raster_cnt
  import rb_ctrl_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int XW    = $clog2(IMG_W),
  parameter int YW    = $clog2(IMG_H)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 adv,
  output logic [XW-1:0]        x,
  output logic [YW-1:0]        y,
  output logic [RB_SLOT_W-1:0] slot,
  output logic                 last_pix,
  output logic                 fill_last,
  output logic                 win_ok
);

  localparam logic [XW-1:0] X_MAX   = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_FRESH = YW'(RBs - 1);
  // With a single row buffer there is no fill phase; the compare value is unused.
  localparam logic [YW-1:0] Y_FILL  = (RBs > 1) ? YW'(RBs - 2) : '0;

  logic x_last;
  logic y_last;

  assign x_last    = (x == X_MAX);
  assign y_last    = (y == Y_MAX);
  assign last_pix  = x_last && y_last;
  assign fill_last = (RBs > 1) && x_last && (y == Y_FILL);
  assign win_ok    = (y >= Y_FRESH);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x    <= '0;
      y    <= '0;
      slot <= '0;
    end else if (adv) begin
      if (x_last) begin
        x    <= '0;
        y    <= y_last ? '0 : y + 1'b1;
        slot <= next_slot(slot);
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rb_ctrl.sv
// Row-buffer sequencer: writes each raster pixel into the packed BRAM and reads
// the matching packed column in the same cycle.
// Latency: 1 cycle from accept to col_* (aligned with the BRAM read data).
// Backpressure: in_ready high only in FILL/STREAM; no output backpressure.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               begin a frame (honoured only in IDLE)
//   in_valid/in_ready   pixel handshake, in_pixel is raster-order data
//   EN_A/ADDR_A/DIN_A   BRAM write port, one pixel at x*RBs + slot
//   EN_B/ADDR_B         BRAM packed-column read port at x
//   col_valid           DOUT_B plus col_pixel/col_slot form a valid window column
//   col_pixel/col_slot  live pixel and the DOUT_B lane it replaces
//   col_x/col_y         coordinates of the emitted column
//   busy, frame_done    not-IDLE flag and end-of-frame pulse
module rb_ctrl
  import rb_ctrl_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int XW    = $clog2(IMG_W),
  parameter int YW    = $clog2(IMG_H)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PIXEL_WIDTH-1:0]       in_pixel,
  output logic                         EN_A,
  output logic [BRAM_W_ADDR_WIDTH-1:0] ADDR_A,
  output logic [BRAM_W_DATA_WIDTH-1:0] DIN_A,
  output logic                         EN_B,
  output logic [BRAM_R_ADDR_WIDTH-1:0] ADDR_B,
  output logic                         col_valid,
  output logic [PIXEL_WIDTH-1:0]       col_pixel,
  output logic [RB_SLOT_W-1:0]         col_slot,
  output logic [XW-1:0]                col_x,
  output logic [YW-1:0]                col_y,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int AW = BRAM_W_ADDR_WIDTH;
  localparam int BW = BRAM_R_ADDR_WIDTH;

  rb_state_t              state;
  logic                   accept;
  logic                   cnt_clear;
  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic [RB_SLOT_W-1:0]   slot;
  logic                   last_pix;
  logic                   fill_last;
  logic                   win_ok;
  logic [AW-1:0]          addr_a_now;
  logic [AW-1:0]          addr_a_q;
  logic [BW-1:0]          addr_b_now;
  logic [BW-1:0]          addr_b_q;

  assign in_ready  = (state == FILL) || (state == STREAM);
  assign accept    = in_valid && in_ready;
  assign cnt_clear = (state == IDLE) && start;

  rb_raster_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .XW    (XW),
    .YW    (YW)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .adv       (accept),
    .x         (x),
    .y         (y),
    .slot      (slot),
    .last_pix  (last_pix),
    .fill_last (fill_last),
    .win_ok    (win_ok)
  );

  // Constant multiply by RBs; the sum is truncated to the write-address width.
  assign addr_a_now = AW'(x) * AW'(RBs) + AW'(slot);
  assign addr_b_now = BW'(x);

  // BRAM ports are driven combinationally from the accept. Addresses keep the
  // value of the last access when idle so the BRAM pins do not toggle.
  assign EN_A   = accept;
  assign EN_B   = accept;
  assign DIN_A  = in_pixel;
  assign ADDR_A = accept ? addr_a_now : addr_a_q;
  assign ADDR_B = accept ? addr_b_now : addr_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_a_q <= '0;
      addr_b_q <= '0;
    end else if (accept) begin
      addr_a_q <= addr_a_now;
      addr_b_q <= addr_b_now;
    end
  end

  // Frame sequencer. busy and frame_done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // A single row buffer needs no priming lines.
            state <= (RBs == 1) ? STREAM : FILL;
            busy  <= 1'b1;
          end
        end
        FILL: begin
          if (accept && fill_last) state <= STREAM;
        end
        STREAM: begin
          if (accept && last_pix) state <= DRAIN;
        end
        DRAIN: begin
          // The last column leaves the output register during this cycle.
          state      <= DONE;
          frame_done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output stage, aligned with the synchronous BRAM read. Columns from lines
  // below RBs-1 would expose lanes never written this frame, so they are
  // suppressed and col_* keep their last valid values.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_valid <= 1'b0;
      col_pixel <= '0;
      col_slot  <= '0;
      col_x     <= '0;
      col_y     <= '0;
    end else begin
      col_valid <= accept && win_ok;
      if (accept && win_ok) begin
        col_pixel <= in_pixel;
        col_slot  <= slot;
        col_x     <= x;
        col_y     <= y;
      end
    end
  end

endmodule

// File: tb/tb_rb_ctrl.sv
module tb_rb_ctrl;
  import rb_ctrl_pkg::*;

  localparam int IW = 8;
  localparam int IH = 6;
  localparam int XW = $clog2(IW);
  localparam int YW = $clog2(IH);

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         start;
  logic                         in_valid;
  logic                         in_ready;
  logic [PIXEL_WIDTH-1:0]       in_pixel;
  logic                         EN_A;
  logic [BRAM_W_ADDR_WIDTH-1:0] ADDR_A;
  logic [BRAM_W_DATA_WIDTH-1:0] DIN_A;
  logic                         EN_B;
  logic [BRAM_R_ADDR_WIDTH-1:0] ADDR_B;
  logic                         col_valid;
  logic [PIXEL_WIDTH-1:0]       col_pixel;
  logic [RB_SLOT_W-1:0]         col_slot;
  logic [XW-1:0]                col_x;
  logic [YW-1:0]                col_y;
  logic                         busy;
  logic                         frame_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rb_ctrl #(.IMG_W(IW), .IMG_H(IH), .XW(XW), .YW(YW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .EN_A(EN_A), .ADDR_A(ADDR_A), .DIN_A(DIN_A),
    .EN_B(EN_B), .ADDR_B(ADDR_B),
    .col_valid(col_valid), .col_pixel(col_pixel), .col_slot(col_slot),
    .col_x(col_x), .col_y(col_y), .busy(busy), .frame_done(frame_done)
  );

  // Packed BRAM model: byte write on A, RBs-wide read on B with old-data
  // read-during-write, output zeroed when not enabled.
  logic [7:0]  mem [0:255];
  logic [31:0] dout_b;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    dout_b = '0;
  end
  always @(posedge clk) begin
    if (EN_B) begin
      for (int k = 0; k < 4; k++) dout_b[k*8 +: 8] <= mem[int'(ADDR_B) * 4 + k];
    end else begin
      dout_b <= '0;
    end
    if (EN_A) mem[ADDR_A] <= DIN_A;
  end

  // Observations gathered by the frame driver.
  int          nvalid, ndone, bad_order, en_leak, last_acc_cyc, done_cyc;
  int          rec_x [64];
  int          rec_y [64];
  int          rec_slot [64];
  int          rec_pix [64];
  logic [31:0] rec_dout [64];
  int          snap_a [48];
  int          snap_b [48];
  int          snap_din [48];
  bit          snap_en [48];

  // Streams one frame starting at posedge+1 with the DUT already started.
  // gaps: in_valid only on even iterations. abort: assert rst at pixel (3,4).
  // glitch_it: iteration at which start is pulsed (-1 for none).
  task automatic drive_frame(input bit gaps, input bit abort, input int glitch_it);
    int px, py, it, ec, post, idx;
    bit acc, seen_done;
    px = 0; py = 0; it = 0; ec = 0; post = 0; seen_done = 0;
    nvalid = 0; ndone = 0; bad_order = 0; en_leak = 0;
    last_acc_cyc = -1; done_cyc = -1;
    while (it < 400 && post < 3) begin
      start    = (it == glitch_it);
      in_valid = (py < IH) && (!gaps || (it % 2 == 0));
      in_pixel = 8'(py * 16 + px);
      if (abort && px == 3 && py == 4) rst = 1'b1;
      #1;
      acc = in_valid && in_ready;
      if (acc) begin
        idx = py * IW + px;
        snap_a[idx]   = int'(ADDR_A);
        snap_b[idx]   = int'(ADDR_B);
        snap_din[idx] = int'(DIN_A);
        snap_en[idx]  = EN_A && EN_B;
      end
      if (!in_valid && (EN_A || EN_B)) en_leak++;
      @(posedge clk);
      ec++;
      #1;
      start = 1'b0;
      if (rst) begin
        in_valid = 1'b0;
        return;
      end
      if (col_valid) begin
        if (!acc) bad_order++;
        if (nvalid < 64) begin
          rec_x[nvalid]    = int'(col_x);
          rec_y[nvalid]    = int'(col_y);
          rec_slot[nvalid] = int'(col_slot);
          rec_pix[nvalid]  = int'(col_pixel);
          rec_dout[nvalid] = dout_b;
        end
        nvalid++;
      end
      if (frame_done) begin
        ndone++;
        done_cyc = ec;
        seen_done = 1'b1;
      end
      if (acc) begin
        last_acc_cyc = ec - 1;
        if (px == IW - 1) begin px = 0; py++; end else px++;
      end
      if (seen_done) post++;
      it++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixel = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({in_ready, EN_A, EN_B, col_valid, busy, frame_done} !== 6'b0) begin
        bad++;
        $display("FAIL reset_ctrl cyc=%0d got=%b want=000000", i,
                 {in_ready, EN_A, EN_B, col_valid, busy, frame_done});
      end
      total++;
      if (ADDR_A !== '0 || ADDR_B !== '0 || col_pixel !== '0 || col_slot !== '0 ||
          col_x !== '0 || col_y !== '0) begin
        bad++;
        $display("FAIL reset_data cyc=%0d addr_a=%0d addr_b=%0d pix=%0h slot=%0d x=%0d y=%0d want all 0",
                 i, ADDR_A, ADDR_B, col_pixel, col_slot, col_x, col_y);
      end
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL start_ready got=%b want=1", in_ready); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%b want=1", busy); end
  endtask

  task automatic test_stream_frame;
    drive_frame(1'b0, 1'b0, -1);
    total++;
    if (nvalid !== 24) begin bad++; $display("FAIL stream_count got=%0d want=24", nvalid); end
    total++;
    if (ndone !== 1) begin bad++; $display("FAIL stream_done_pulses got=%0d want=1", ndone); end
    total++;
    if (done_cyc - last_acc_cyc !== 2) begin
      bad++; $display("FAIL stream_done_delay got=%0d want=2", done_cyc - last_acc_cyc);
    end
    total++;
    if (bad_order !== 0) begin bad++; $display("FAIL stream_valid_no_accept got=%0d want=0", bad_order); end
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL stream_idle_after busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
    for (int n = 0; n < 24; n++) begin
      int ey, ex, es, d;
      logic [31:0] ed, msk;
      ey = 3 + n / 8; ex = n % 8; es = ey % 4; ed = '0; msk = '0;
      for (int k = 0; k < 4; k++) begin
        d = (es - k + 4) % 4;
        if (d == 0) d = 4;
        if (ey - d >= 0) begin ed[k*8 +: 8] = 8'((ey - d) * 16 + ex); msk[k*8 +: 8] = 8'hFF; end
      end
      total++;
      if (rec_x[n] !== ex || rec_y[n] !== ey || rec_slot[n] !== es || rec_pix[n] !== ey * 16 + ex) begin
        bad++;
        $display("FAIL stream_col n=%0d got x=%0d y=%0d slot=%0d pix=%0h want x=%0d y=%0d slot=%0d pix=%0h",
                 n, rec_x[n], rec_y[n], rec_slot[n], rec_pix[n], ex, ey, es, ey * 16 + ex);
      end
      total++;
      if ((rec_dout[n] & msk) !== ed) begin
        bad++; $display("FAIL stream_dout n=%0d got=%h want=%h mask=%h", n, rec_dout[n], ed, msk);
      end
    end
  endtask

  task automatic test_write_addr;
    total++;
    if (snap_en[21] !== 1'b1 || snap_a[21] !== 22 || snap_din[21] !== 8'h25 || snap_b[21] !== 5) begin
      bad++;
      $display("FAIL waddr_5_2 got en=%b a=%0d din=%0h b=%0d want en=1 a=22 din=25 b=5",
               snap_en[21], snap_a[21], snap_din[21], snap_b[21]);
    end
    total++;
    if (snap_a[32] !== 0 || snap_b[32] !== 0 || snap_din[32] !== 8'h40) begin
      bad++;
      $display("FAIL waddr_0_4 got a=%0d b=%0d din=%0h want a=0 b=0 din=40",
               snap_a[32], snap_b[32], snap_din[32]);
    end
    total++;
    if (snap_a[47] !== 29 || snap_b[47] !== 7) begin
      bad++; $display("FAIL waddr_7_5 got a=%0d b=%0d want a=29 b=7", snap_a[47], snap_b[47]);
    end
  endtask

  task automatic test_first_window;
    total++;
    if (rec_x[0] !== 0 || rec_y[0] !== 3 || rec_slot[0] !== 3 || rec_pix[0] !== 8'h30) begin
      bad++;
      $display("FAIL first_col got x=%0d y=%0d slot=%0d pix=%0h want x=0 y=3 slot=3 pix=30",
               rec_x[0], rec_y[0], rec_slot[0], rec_pix[0]);
    end
    total++;
    if (rec_dout[0][23:0] !== 24'h201000) begin
      bad++; $display("FAIL first_lanes got=%h want=201000", rec_dout[0][23:0]);
    end
    total++;
    if (rec_slot[15] !== 0 || rec_pix[15] !== 8'h47 || rec_dout[15][31:8] !== 24'h372717) begin
      bad++;
      $display("FAIL col_7_4 got slot=%0d pix=%0h lanes=%h want slot=0 pix=47 lanes=372717",
               rec_slot[15], rec_pix[15], rec_dout[15][31:8]);
    end
  endtask

  task automatic test_gaps;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drive_frame(1'b1, 1'b0, -1);
    total++;
    if (nvalid !== 24) begin bad++; $display("FAIL gaps_count got=%0d want=24", nvalid); end
    total++;
    if (bad_order !== 0) begin bad++; $display("FAIL gaps_valid_no_accept got=%0d want=0", bad_order); end
    total++;
    if (en_leak !== 0) begin bad++; $display("FAIL gaps_en_idle got=%0d want=0", en_leak); end
    total++;
    if (ndone !== 1 || done_cyc - last_acc_cyc !== 2) begin
      bad++; $display("FAIL gaps_done got pulses=%0d delay=%0d want 1 2", ndone, done_cyc - last_acc_cyc);
    end
    for (int n = 0; n < 24; n++) begin
      int ey, ex, es, d;
      logic [31:0] ed, msk;
      ey = 3 + n / 8; ex = n % 8; es = ey % 4; ed = '0; msk = '0;
      for (int k = 0; k < 4; k++) begin
        d = (es - k + 4) % 4;
        if (d == 0) d = 4;
        if (ey - d >= 0) begin ed[k*8 +: 8] = 8'((ey - d) * 16 + ex); msk[k*8 +: 8] = 8'hFF; end
      end
      total++;
      if (rec_x[n] !== ex || rec_y[n] !== ey || rec_slot[n] !== es || rec_pix[n] !== ey * 16 + ex ||
          (rec_dout[n] & msk) !== ed) begin
        bad++;
        $display("FAIL gaps_col n=%0d got x=%0d y=%0d slot=%0d pix=%0h dout=%h want x=%0d y=%0d slot=%0d pix=%0h dout=%h",
                 n, rec_x[n], rec_y[n], rec_slot[n], rec_pix[n], rec_dout[n] & msk, ex, ey, es, ey * 16 + ex, ed);
      end
    end
  endtask

  task automatic test_abort;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drive_frame(1'b0, 1'b1, -1);
    total++;
    if ({busy, in_ready, col_valid, EN_A} !== 4'b0) begin
      bad++; $display("FAIL abort_state got=%b want=0000", {busy, in_ready, col_valid, EN_A});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // start pulsed again during FILL must not restart the counters
    drive_frame(1'b0, 1'b0, 5);
    total++;
    if (rec_slot[0] !== 3 || rec_y[0] !== 3 || rec_x[0] !== 0 || rec_pix[0] !== 8'h30) begin
      bad++;
      $display("FAIL restart_first got slot=%0d y=%0d x=%0d pix=%0h want slot=3 y=3 x=0 pix=30",
               rec_slot[0], rec_y[0], rec_x[0], rec_pix[0]);
    end
    total++;
    if (nvalid !== 24 || ndone !== 1) begin
      bad++; $display("FAIL restart_count got cols=%0d done=%0d want 24 1", nvalid, ndone);
    end
    total++;
    if (rec_dout[0][23:0] !== 24'h201000 || rec_dout[15][31:8] !== 24'h372717 || rec_pix[23] !== 8'h57) begin
      bad++;
      $display("FAIL restart_data got l0=%h l15=%h p23=%0h want 201000 372717 57",
               rec_dout[0][23:0], rec_dout[15][31:8], rec_pix[23]);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL restart_busy got=%b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_stream_frame();
    test_write_addr();
    test_first_window();
    test_gaps();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
